// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the integer-pipe (IP) and load/store-pipe (LSP)
// writeback streams onto the single register-file write port.
// Each source owns a small in-order queue; queue heads are granted
// oldest-first by age stamp, equal stamps are broken by a round-robin
// pointer. The granted head is registered into the output stage, so a
// request accepted at edge k drives rf_wen after edge k+1.
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,   // entries per source queue, power of two, 2..4
  parameter int SW    = 4    // age-stamp width, 2^(SW-1) > 2*DEPTH+1
) (
  input  logic            clk,
  input  logic            rst,
  // integer-pipe writeback
  input  logic            ip_wb_valid,
  output logic            ip_wb_ready,
  input  logic            ip_wb_wb_en,
  input  logic [4:0]      ip_wb_dst,
  input  logic [XLEN-1:0] ip_wb_result,
  // load/store-pipe writeback
  input  logic            lsp_wb_valid,
  output logic            lsp_wb_ready,
  input  logic            lsp_wb_wb_en,
  input  logic [4:0]      lsp_wb_dst,
  input  logic [XLEN-1:0] lsp_wb_result,
  // register-file write port
  output logic            rf_wen,
  output logic [4:0]      rf_wdst,
  output logic [XLEN-1:0] rf_wdata,
  // issue-stage visibility
  output logic [31:0]     wba_pend_mask,
  output logic            wba_busy
);

  localparam int NSRC = 2;
  localparam int PW   = $clog2(DEPTH);      // queue pointer width
  localparam int CW   = $clog2(DEPTH + 1);  // queue occupancy width

  // Source identifiers; also the encoding of the round-robin pointer.
  localparam logic SRC_IP  = 1'b0;
  localparam logic SRC_LSP = 1'b1;

  // ------------------------------------------------------------------
  // Per-source input bundles, indexed by SRC_IP / SRC_LSP
  // ------------------------------------------------------------------
  logic [NSRC-1:0] in_valid;
  logic [NSRC-1:0] in_wb_en;
  logic [4:0]      in_dst  [NSRC];
  logic [XLEN-1:0] in_data [NSRC];

  assign in_valid   = {lsp_wb_valid, ip_wb_valid};
  assign in_wb_en   = {lsp_wb_wb_en, ip_wb_wb_en};
  assign in_dst[0]  = ip_wb_dst;
  assign in_dst[1]  = lsp_wb_dst;
  assign in_data[0] = ip_wb_result;
  assign in_data[1] = lsp_wb_result;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [4:0]      dst_mem_q   [NSRC][DEPTH];
  logic [XLEN-1:0] data_mem_q  [NSRC][DEPTH];
  logic [SW-1:0]   stamp_mem_q [NSRC][DEPTH];

  logic [PW-1:0]   rd_ptr_q [NSRC];
  logic [PW-1:0]   rd_ptr_d [NSRC];
  logic [PW-1:0]   wr_ptr_q [NSRC];
  logic [PW-1:0]   wr_ptr_d [NSRC];
  logic [CW-1:0]   count_q  [NSRC];
  logic [CW-1:0]   count_d  [NSRC];

  logic [SW-1:0]   stamp_q, stamp_d;
  logic            rr_q, rr_d;

  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_wdst_q, rf_wdst_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  // ------------------------------------------------------------------
  // Queue heads
  // ------------------------------------------------------------------
  logic [NSRC-1:0] head_vld;
  logic [SW-1:0]   head_stamp [NSRC];
  logic [4:0]      head_dst   [NSRC];
  logic [XLEN-1:0] head_data  [NSRC];

  // Expose the oldest entry of each queue to the arbiter.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    head_vld = '0;
    for (int s = 0; s < NSRC; s++) begin
      head_vld[s]   = (count_q[s] != '0);
      head_stamp[s] = stamp_mem_q[s][rd_ptr_q[s]];
      head_dst[s]   = dst_mem_q[s][rd_ptr_q[s]];
      head_data[s]  = data_mem_q[s][rd_ptr_q[s]];
    end
  end

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  logic [SW-1:0]   age_diff;
  logic            ip_older;
  logic            tie;
  logic            gnt_any;
  logic            gnt_src;
  logic [NSRC-1:0] gnt;

  // Grant the older head; equal stamps go to the round-robin pointer.
  always_comb begin
    // Modular difference: a set MSB means the IP head was stamped first.
    age_diff = head_stamp[0] - head_stamp[1];
    ip_older = (age_diff >= SW'(1 << (SW - 1)));
    tie      = 1'b0;
    gnt_any  = |head_vld;
    gnt_src  = SRC_IP;
    if (head_vld[0] && head_vld[1]) begin
      if (head_stamp[0] == head_stamp[1]) begin
        tie     = 1'b1;
        gnt_src = rr_q;
      end else if (ip_older) begin
        gnt_src = SRC_IP;
      end else begin
        gnt_src = SRC_LSP;
      end
    end else if (head_vld[1]) begin
      gnt_src = SRC_LSP;
    end
    gnt[0] = gnt_any && (gnt_src == SRC_IP);
    gnt[1] = gnt_any && (gnt_src == SRC_LSP);
  end

  // ------------------------------------------------------------------
  // Enqueue side
  // ------------------------------------------------------------------
  logic [NSRC-1:0] ready;
  logic [NSRC-1:0] fire;
  logic [NSRC-1:0] push;

  // Ready depends only on registered occupancy and the grant, never on valid.
  // Requests that write nothing (wb_en=0 or dst=0) are handshaken and dropped.
  always_comb begin
    ready = '0;
    fire  = '0;
    push  = '0;
    for (int s = 0; s < NSRC; s++) begin
      ready[s] = (count_q[s] < CW'(DEPTH)) || gnt[s];
      fire[s]  = in_valid[s] && ready[s];
      push[s]  = fire[s] && in_wb_en[s] && (in_dst[s] != 5'd0);
    end
  end

  // ------------------------------------------------------------------
  // Next-state computation
  // ------------------------------------------------------------------

  // Pointer/occupancy updates, stamp advance, round-robin flip, output stage.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      rd_ptr_d[s] = gnt[s]  ? rd_ptr_q[s] + PW'(1) : rd_ptr_q[s];
      wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PW'(1) : wr_ptr_q[s];
      count_d[s]  = count_q[s] + CW'(push[s]) - CW'(gnt[s]);
    end

    // Both sources enqueuing on the same edge share one stamp value.
    stamp_d = (|push) ? stamp_q + SW'(1) : stamp_q;

    // The pointer moves only when it actually decided a tie.
    rr_d = (gnt_any && tie) ? ~gnt_src : rr_q;

    rf_wen_d   = gnt_any;
    rf_wdst_d  = gnt_any ? head_dst[gnt_src]  : rf_wdst_q;
    rf_wdata_d = gnt_any ? head_data[gnt_src] : rf_wdata_q;
  end

  // ------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------

  // Control state and output stage; reset empties both queues at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      stamp_q    <= '0;
      rr_q       <= SRC_IP;
      rf_wen_q   <= 1'b0;
      rf_wdst_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        rd_ptr_q[s] <= rd_ptr_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
        count_q[s]  <= count_d[s];
      end
      stamp_q    <= stamp_d;
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_wdst_q  <= rf_wdst_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Queue storage written at the tail on each real enqueue.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays are deliberately not reset; occupancy and
    // pointers alone decide which entries are live, so stale contents are
    // never observed.
    for (int s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        dst_mem_q[s][wr_ptr_q[s]]   <= in_dst[s];
        data_mem_q[s][wr_ptr_q[s]]  <= in_data[s];
        stamp_mem_q[s][wr_ptr_q[s]] <= stamp_q;
      end
    end
  end

  // ------------------------------------------------------------------
  // Pending-destination mask
  // ------------------------------------------------------------------
  logic [31:0]   pend_mask;
  logic [PW-1:0] slot;

  // OR of every live queue entry plus the output stage; x0 never pends.
  always_comb begin
    pend_mask = '0;
    slot      = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = rd_ptr_q[s] + PW'(i);
        if (CW'(i) < count_q[s]) begin
          pend_mask[dst_mem_q[s][slot]] = 1'b1;
        end
      end
    end
    if (rf_wen_q) begin
      pend_mask[rf_wdst_q] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign ip_wb_ready   = ready[0];
  assign lsp_wb_ready  = ready[1];
  assign rf_wen        = rf_wen_q;
  assign rf_wdst       = rf_wdst_q;
  assign rf_wdata      = rf_wdata_q;
  assign wba_pend_mask = pend_mask;
  assign wba_busy      = (count_q[0] != '0) || (count_q[1] != '0) || rf_wen_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model that orders entries by a global sequence
// number instead of wrapping stamps.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int SW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ip_wb_valid, ip_wb_ready, ip_wb_wb_en;
  logic [4:0]      ip_wb_dst;
  logic [XLEN-1:0] ip_wb_result;
  logic            lsp_wb_valid, lsp_wb_ready, lsp_wb_wb_en;
  logic [4:0]      lsp_wb_dst;
  logic [XLEN-1:0] lsp_wb_result;
  logic            rf_wen;
  logic [4:0]      rf_wdst;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     wba_pend_mask;
  logic            wba_busy;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ip_wb_valid   (ip_wb_valid),
    .ip_wb_ready   (ip_wb_ready),
    .ip_wb_wb_en   (ip_wb_wb_en),
    .ip_wb_dst     (ip_wb_dst),
    .ip_wb_result  (ip_wb_result),
    .lsp_wb_valid  (lsp_wb_valid),
    .lsp_wb_ready  (lsp_wb_ready),
    .lsp_wb_wb_en  (lsp_wb_wb_en),
    .lsp_wb_dst    (lsp_wb_dst),
    .lsp_wb_result (lsp_wb_result),
    .rf_wen        (rf_wen),
    .rf_wdst       (rf_wdst),
    .rf_wdata      (rf_wdata),
    .wba_pend_mask (wba_pend_mask),
    .wba_busy      (wba_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: two FIFOs of {dst, data, seq}; smaller seq is older.
  // ------------------------------------------------------------------
  typedef struct {
    logic [4:0]      dst;
    logic [XLEN-1:0] data;
    int              seq;
  } ent_t;

  ent_t            mq_ip[$];
  ent_t            mq_lsp[$];
  int              m_seq  = 0;
  bit              m_rr   = 1'b0;   // 0 = IP next on a tie
  bit              m_wen  = 1'b0;
  logic [4:0]      m_dst  = '0;
  logic [XLEN-1:0] m_data = '0;

  // Compare DUT against the model mid-cycle, then advance the model over the next edge.
  always @(negedge clk) begin : cmp
    int          g;
    bit          tie;
    bit          rdy_ip, rdy_lsp, any;
    logic [31:0] pm;
    ent_t        e;
    if (rst) begin
      mq_ip.delete();
      mq_lsp.delete();
      m_seq  = 0;
      m_rr   = 1'b0;
      m_wen  = 1'b0;
      m_dst  = '0;
      m_data = '0;
      check("rst_rf_wen", rf_wen, 0);
      check("rst_rf_wdst", rf_wdst, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_ip_ready", ip_wb_ready, 1);
      check("rst_lsp_ready", lsp_wb_ready, 1);
      check("rst_pend_mask", wba_pend_mask, 0);
      check("rst_busy", wba_busy, 0);
    end else begin
      g   = -1;
      tie = 1'b0;
      if (mq_ip.size() > 0 && mq_lsp.size() > 0) begin
        if (mq_ip[0].seq < mq_lsp[0].seq)      g = 0;
        else if (mq_lsp[0].seq < mq_ip[0].seq) g = 1;
        else begin
          g   = m_rr ? 1 : 0;
          tie = 1'b1;
        end
      end else if (mq_ip.size() > 0) begin
        g = 0;
      end else if (mq_lsp.size() > 0) begin
        g = 1;
      end
      rdy_ip  = (mq_ip.size() < DEPTH) || (g == 0);
      rdy_lsp = (mq_lsp.size() < DEPTH) || (g == 1);
      pm = '0;
      foreach (mq_ip[i])  pm[mq_ip[i].dst]  = 1'b1;
      foreach (mq_lsp[i]) pm[mq_lsp[i].dst] = 1'b1;
      if (m_wen) pm[m_dst] = 1'b1;
      pm[0] = 1'b0;

      check("ip_ready", ip_wb_ready, rdy_ip);
      check("lsp_ready", lsp_wb_ready, rdy_lsp);
      check("rf_wen", rf_wen, m_wen);
      if (m_wen) begin
        check("rf_wdst", rf_wdst, m_dst);
        check("rf_wdata", rf_wdata, m_data);
      end
      check("pend_mask", wba_pend_mask, pm);
      check("busy", wba_busy, (mq_ip.size() + mq_lsp.size() > 0) || m_wen);

      if (g == 0) begin
        m_wen = 1'b1; m_dst = mq_ip[0].dst; m_data = mq_ip[0].data;
        void'(mq_ip.pop_front());
      end else if (g == 1) begin
        m_wen = 1'b1; m_dst = mq_lsp[0].dst; m_data = mq_lsp[0].data;
        void'(mq_lsp.pop_front());
      end else begin
        m_wen = 1'b0;
      end
      if (tie) m_rr = !m_rr;

      any = 1'b0;
      if (ip_wb_valid && rdy_ip && ip_wb_wb_en && ip_wb_dst != 5'd0) begin
        e.dst = ip_wb_dst; e.data = ip_wb_result; e.seq = m_seq;
        mq_ip.push_back(e);
        any = 1'b1;
      end
      if (lsp_wb_valid && rdy_lsp && lsp_wb_wb_en && lsp_wb_dst != 5'd0) begin
        e.dst = lsp_wb_dst; e.data = lsp_wb_result; e.seq = m_seq;
        mq_lsp.push_back(e);
        any = 1'b1;
      end
      if (any) m_seq++;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic set_ip(input bit v, input bit en, input logic [4:0] d, input logic [63:0] x);
    ip_wb_valid = v; ip_wb_wb_en = en; ip_wb_dst = d; ip_wb_result = x;
  endtask

  task automatic set_lsp(input bit v, input bit en, input logic [4:0] d, input logic [63:0] x);
    lsp_wb_valid = v; lsp_wb_wb_en = en; lsp_wb_dst = d; lsp_wb_result = x;
  endtask

  task automatic idle();
    set_ip(0, 0, 5'd0, 64'd0);
    set_lsp(0, 0, 5'd0, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] got[$];

  task automatic sample_write();
    if (rf_wen) got.push_back(rf_wdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lsp_sent, lsp_seen, cur_low, max_low, n;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // --- Single IP write: latency and pend-mask window ---
    set_ip(1, 1, 5'd5, 64'hA);
    tick();                                   // edge 1: accepted
    idle();
    check("s1_pend_e1", wba_pend_mask[5], 1);
    check("s1_wen_e1", rf_wen, 0);
    tick();                                   // edge 2: in output stage
    check("s1_wen_e2", rf_wen, 1);
    check("s1_dst_e2", rf_wdst, 5);
    check("s1_data_e2", rf_wdata, 64'hA);
    check("s1_pend_e2", wba_pend_mask[5], 1);
    tick();                                   // edge 3: written
    check("s1_wen_e3", rf_wen, 0);
    check("s1_pend_e3", wba_pend_mask, 0);
    check("s1_busy_e3", wba_busy, 0);

    // --- Equal-age ties: first to IP, second to LSP ---
    set_ip(1, 1, 5'd3, 64'h33);
    set_lsp(1, 1, 5'd4, 64'h44);
    tick();
    idle();
    tick();
    check("s2a_first_dst", rf_wdst, 3);
    check("s2a_first_wen", rf_wen, 1);
    tick();
    check("s2a_second_dst", rf_wdst, 4);
    check("s2a_second_data", rf_wdata, 64'h44);
    tick();
    check("s2a_idle_wen", rf_wen, 0);
    set_ip(1, 1, 5'd3, 64'h33);
    set_lsp(1, 1, 5'd4, 64'h44);
    tick();
    idle();
    tick();
    check("s2b_first_dst", rf_wdst, 4);
    tick();
    check("s2b_second_dst", rf_wdst, 3);
    tick();

    // --- Same destination across sources commits in age order ---
    got.delete();
    set_ip(1, 1, 5'd7, 64'h10);
    set_lsp(1, 1, 5'd7, 64'h20);
    tick(); sample_write();
    set_ip(0, 0, 5'd0, 64'd0);
    set_lsp(1, 1, 5'd7, 64'h2);
    tick(); sample_write();
    set_lsp(0, 0, 5'd0, 64'd0);
    set_ip(1, 1, 5'd7, 64'h1);
    tick(); sample_write();
    idle();
    repeat (6) begin tick(); sample_write(); end
    check("s3_write_count", got.size(), 4);
    if (got.size() == 4) begin
      check("s3_order0", got[0], 64'h10);
      check("s3_order1", got[1], 64'h20);
      check("s3_order2", got[2], 64'h2);
      check("s3_order3", got[3], 64'h1);
    end

    // --- Discarded requests: wb_en=0 and dst=0 ---
    set_ip(1, 0, 5'd9, 64'h99);
    set_lsp(1, 1, 5'd0, 64'h77);
    check("s4_ip_ready", ip_wb_ready, 1);
    check("s4_lsp_ready", lsp_wb_ready, 1);
    tick();
    set_ip(1, 1, 5'd0, 64'h98);
    set_lsp(1, 0, 5'd12, 64'h76);
    tick();
    idle();
    check("s4_pend_after", wba_pend_mask, 0);
    check("s4_busy_after", wba_busy, 0);
    tick();
    check("s4_wen_after", rf_wen, 0);

    // --- LSP held valid while IP floods: bounded stall, nothing lost ---
    lsp_sent = 0; lsp_seen = 0; cur_low = 0; max_low = 0; n = 0;
    while (lsp_sent < 6 && n < 60) begin
      set_ip(1, 1, 5'($urandom_range(1, 31)), {8'hA0, 56'(n)});
      set_lsp(1, 1, 5'($urandom_range(1, 31)), {8'hB0, 56'(lsp_sent)});
      if (lsp_wb_ready) begin
        lsp_sent++;
        cur_low = 0;
      end else begin
        cur_low++;
        if (cur_low > max_low) max_low = cur_low;
      end
      tick();
      if (rf_wen && rf_wdata[63:56] == 8'hB0) lsp_seen++;
      n++;
    end
    idle();
    repeat (12) begin
      tick();
      if (rf_wen && rf_wdata[63:56] == 8'hB0) lsp_seen++;
    end
    check("s5_lsp_accepted", lsp_sent, 6);
    check("s5_lsp_stall_bounded", (max_low <= DEPTH), 1);
    check("s5_lsp_writes_seen", lsp_seen, 6);

    // --- Asynchronous reset with both queues full and a write in flight ---
    repeat (4) begin
      set_ip(1, 1, 5'($urandom_range(1, 31)), 64'($urandom));
      set_lsp(1, 1, 5'($urandom_range(1, 31)), 64'($urandom));
      tick();
    end
    check("s6_pre_wen", rf_wen, 1);
    check("s6_pre_busy", wba_busy, 1);
    #2 rst = 1'b1;
    idle();
    #1;
    check("s6_async_wen", rf_wen, 0);
    check("s6_async_pend", wba_pend_mask, 0);
    check("s6_async_ip_ready", ip_wb_ready, 1);
    check("s6_async_lsp_ready", lsp_wb_ready, 1);
    check("s6_async_busy", wba_busy, 0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("s6_post_wen", rf_wen, 0);
    end

    // --- Randomized traffic with occasional mid-run resets ---
    for (int c = 0; c < 1500; c++) begin
      int pv;
      pv = (c / 250) % 3;   // phase: light, heavy, saturating
      set_ip($urandom_range(0, 3) < pv + 1, $urandom_range(0, 9) != 0,
             5'($urandom), {$urandom, $urandom});
      set_lsp($urandom_range(0, 3) < pv + 1, $urandom_range(0, 9) != 0,
              5'($urandom), {$urandom, $urandom});
      if (c % 500 == 499) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    repeat (10) tick();
    check("final_busy", wba_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
